fifo_param_flags: RTL and testbench
===================================

Name: fifo_param_flags

Overview:
Parametrised single-clock FIFO, successor to the basic put/get FIFO in the DDR2 controller datapath (command queue, write-data and read-return buffers).
- Adds selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Defines put/get acceptance explicitly at every full/empty boundary, including simultaneous put+get.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 64, number of entries; power of two, >= 2
DEPTH_LOG2, 6, log2(DEPTH); pointer width
AF_THRESH, 60, almost_full asserted when fillcount >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserted when fillcount <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
flush  input  1  synchronous clear of contents and error flags
data_in  input  WIDTH  write data
put  input  1  write request
get  input  1  read request
data_out  output  WIDTH  read data
data_valid  output  1  standard mode: data_out updated this cycle; FWFT: equals empty_bar
empty_bar  output  1  1 = at least one word stored
full_bar  output  1  1 = at least one free entry
almost_full  output  1  fillcount >= AF_THRESH
almost_empty  output  1  fillcount <= AE_THRESH
overflow  output  1  sticky: put attempted while full
underflow  output  1  sticky: get attempted while empty
fillcount  output  DEPTH_LOG2+1  words stored, 0..DEPTH

Behaviour:
- Reset (reset==0, async): wr_ptr, rd_ptr, fillcount = 0; data_out = 0; data_valid = 0; overflow = underflow = 0. Derived outputs: empty_bar=0, full_bar=1, almost_full=0, almost_empty=1. Memory contents are not reset. Deassertion is taken synchronously to clk by the instantiating level.
- Flush (sync, reset deasserted): same state as reset at next edge. Flush has priority over put/get in that cycle; data_in is not written.
- Acceptance, evaluated on pre-edge state:
  - put_ok = put & full_bar
  - get_ok = get & empty_bar
- put_ok: mem[wr_ptr] <= data_in; wr_ptr += 1 (wraps DEPTH-1 -> 0 naturally via DEPTH_LOG2 bits).
- get_ok: rd_ptr += 1 (same wrap).
- fillcount: +1 if put_ok only; -1 if get_ok only; unchanged if both or neither. Never leaves 0..DEPTH.
- Simultaneous put+get:
  - 0<fill<DEPTH: both accepted, fill unchanged.
  - fill==0: put accepted, get rejected, underflow set, fill -> 1.
  - fill==DEPTH: get accepted, put rejected, overflow set, fill -> DEPTH-1.
- Errors: overflow <= 1 on put & !full_bar; underflow <= 1 on get & !empty_bar. Both hold until reset or flush.
- Standard mode (FWFT=0):
  - On get_ok, data_out <= mem[rd_ptr] at the edge (1-cycle latency) and data_valid pulses high for exactly that following cycle.
  - data_out holds its last value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally and is valid whenever empty_bar=1; get_ok consumes the head.
  - data_valid = empty_bar.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Flags are combinational from fillcount: full_bar = (fillcount != DEPTH), empty_bar = (fillcount != 0).
- Invalid thresholds are rejected at elaboration (generate-time check).

Decomposition:
- Shared header ddr2_fifo_defs: default WIDTH/DEPTH constants for controller queues, plus FWFT mode encodings (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_dp_mem (DEPTH x WIDTH):
  - one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Top level holds pointers, counter, flags and the output register.

Test Plan:
- Reset/flags: reset=0 mid-stream with fill=5 -> immediately fillcount=0, empty_bar=0, full_bar=1, almost_empty=1, data_out=0, overflow=underflow=0.
- Fill/drain, FWFT=0, DEPTH=64: put 0x00..0x3F -> full_bar=0 after 64th edge; almost_full rises at fill=60; get x64 -> data_out 0x00..0x3F in order, one cycle after each get; data_valid pulses each time.
- Boundary errors: put while full -> fill stays 64, overflow=1, mem intact; get while empty -> underflow=1, fill stays 0, data_out unchanged; flush -> both cleared, fill=0.
- Simultaneous put+get:
  - fill=10: fill stays 10, order preserved across wrap after 100 cycles.
  - fill=0: fill -> 1, underflow=1.
  - fill=64: fill -> 63, overflow=1, next data out is the oldest word.
- FWFT=1: put 0xA5 into empty FIFO -> next cycle data_out=0xA5, data_valid=1 with no get; put 0x5A, get -> data_out=0x5A same cycle after edge; get -> empty_bar=0, data_valid=0.
- Threshold params AF_THRESH=2, AE_THRESH=1, DEPTH=4: fill 0->4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,1,1,1.

Source files
------------

// File: rtl/ddr2_fifo_defs.sv
// Shared defaults and mode encodings
// for the DDR2 controller queues.
package ddr2_fifo_defs;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_DEPTH      = 64;
  localparam int FIFO_DEPTH_LOG2 = 6;
  localparam int FIFO_AF_THRESH  = 60;
  localparam int FIFO_AE_THRESH  = 4;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_dp_mem.sv
// Storage array: one synchronous write
// port, one asynchronous read port.
module fifo_dp_mem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param_flags.sv
// Single-clock FIFO with FWFT option,
// threshold flags and sticky errors.
module fifo_param_flags
  import ddr2_fifo_defs::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  put,
  input  logic                  get,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  empty_bar,
  output logic                  full_bar,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   fillcount
);

  localparam int PW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 2 || DEPTH != (1 << DEPTH_LOG2)) begin : g_bad_depth
    $error("fifo_param_flags: DEPTH must be 2**DEPTH_LOG2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_param_flags: AF_THRESH out of 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param_flags: AE_THRESH out of 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("fifo_param_flags: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, udf_q;
  logic             put_ok, get_ok;
  logic [WIDTH-1:0] rdata;

  assign empty_bar    = (cnt_q != '0);
  assign full_bar     = (cnt_q != DEPTH_C);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign fillcount    = cnt_q;

  assign put_ok = put & full_bar & ~flush;
  assign get_ok = get & empty_bar & ~flush;

  // occupancy moves only when exactly one side is accepted
  always_comb begin
    cnt_d = cnt_q;
    unique case ({put_ok, get_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (put_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (get_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      if (put && !full_bar)  ovf_q <= 1'b1;
      if (get && !empty_bar) udf_q <= 1'b1;
    end
  end

  fifo_dp_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (put_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // head word is presented directly; zero while empty
    assign data_out   = empty_bar ? rdata : '0;
    assign data_valid = empty_bar;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;

    // registered read: one-cycle latency, valid pulses once per get
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else if (flush) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= get_ok;
        if (get_ok) dout_q <= rdata;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end

endmodule

// File: tb/tb_fifo_param_flags.sv
// Bench: standard 64-deep instance (a) and
// FWFT 4-deep threshold instance (b) vs queue models.
module tb_fifo_param_flags;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       fl_a, put_a, get_a;
  logic [7:0] din_a, dout_a;
  logic       dv_a, eb_a, fb_a, af_a, ae_a, ov_a, un_a;
  logic [6:0] fc_a;

  logic       fl_b, put_b, get_b;
  logic [7:0] din_b, dout_b;
  logic       dv_b, eb_b, fb_b, af_b, ae_b, ov_b, un_b;
  logic [2:0] fc_b;

  fifo_param_flags u_a (
    .clk(clk), .reset(rst_n), .flush(fl_a),
    .data_in(din_a), .put(put_a), .get(get_a),
    .data_out(dout_a), .data_valid(dv_a),
    .empty_bar(eb_a), .full_bar(fb_a),
    .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ov_a), .underflow(un_a),
    .fillcount(fc_a)
  );

  fifo_param_flags #(
    .WIDTH(8), .DEPTH(4), .DEPTH_LOG2(2),
    .AF_THRESH(2), .AE_THRESH(1), .FWFT(1)
  ) u_b (
    .clk(clk), .reset(rst_n), .flush(fl_b),
    .data_in(din_b), .put(put_b), .get(get_b),
    .data_out(dout_b), .data_valid(dv_b),
    .empty_bar(eb_b), .full_bar(fb_b),
    .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ov_b), .underflow(un_b),
    .fillcount(fc_b)
  );

  int total = 0;
  int bad   = 0;

  // reference models: queues of stored words
  int   qa[$];
  int   qb[$];
  logic ma_ov, ma_un, ma_dv;
  logic [7:0] ma_dout;
  logic mb_ov, mb_un;

  function automatic logic [21:0] obs_a();
    return {fc_a, eb_a, fb_a, af_a, ae_a, ov_a, un_a, dv_a, dout_a};
  endfunction

  function automatic logic [21:0] exp_a();
    int f = qa.size();
    return {7'(f), f != 0, f != 64, f >= 60, f <= 4,
            ma_ov, ma_un, ma_dv, ma_dout};
  endfunction

  function automatic logic [17:0] obs_b();
    return {fc_b, eb_b, fb_b, af_b, ae_b, ov_b, un_b, dv_b, dout_b};
  endfunction

  function automatic logic [17:0] exp_b();
    int f = qb.size();
    logic [7:0] h = (f != 0) ? 8'(qb[0]) : 8'h00;
    return {3'(f), f != 0, f != 4, f >= 2, f <= 1,
            mb_ov, mb_un, f != 0, h};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    ma_ov = 0; ma_un = 0; ma_dv = 0; ma_dout = 8'h00;
    mb_ov = 0; mb_un = 0;
  endtask

  task automatic idle();
    fl_a = 0; put_a = 0; get_a = 0; din_a = 8'h00;
    fl_b = 0; put_b = 0; get_b = 0; din_b = 8'h00;
  endtask

  // one clock: models follow the pre-edge rules, then wait to negedge
  task automatic tick();
    bit pok, gok;
    @(posedge clk);
    if (rst_n) begin
      if (fl_a) begin
        qa.delete(); ma_ov = 0; ma_un = 0; ma_dv = 0; ma_dout = 8'h00;
      end else begin
        pok = put_a && qa.size() < 64;
        gok = get_a && qa.size() > 0;
        if (put_a && !pok) ma_ov = 1;
        if (get_a && !gok) ma_un = 1;
        ma_dv = gok;
        if (gok) ma_dout = 8'(qa.pop_front());
        if (pok) qa.push_back(int'(din_a));
      end
      if (fl_b) begin
        qb.delete(); mb_ov = 0; mb_un = 0;
      end else begin
        pok = put_b && qb.size() < 4;
        gok = get_b && qb.size() > 0;
        if (put_b && !pok) mb_ov = 1;
        if (get_b && !gok) mb_un = 1;
        if (gok) void'(qb.pop_front());
        if (pok) qb.push_back(int'(din_b));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL reset_a: got %h want %h", obs_a(), exp_a());
    end
    total++;
    if (obs_b() !== exp_b()) begin
      bad++;
      $display("FAIL reset_b: got %h want %h", obs_b(), exp_b());
    end
    for (int i = 0; i < 5; i++) begin
      put_a = 1; din_a = 8'($urandom);
      tick();
    end
    put_a = 1'b0; get_a = 1'b1;
    tick();
    get_a = 1'b0; put_a = 1'b1; din_a = 8'h77;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL prefill5: got %h want %h", obs_a(), exp_a());
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", obs_a(), exp_a());
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 64; i++) begin
      put_a = 1; din_a = 8'(i);
      tick();
      total++;
      if (obs_a() !== exp_a()) begin
        bad++;
        $display("FAIL fill[%0d]: got %h want %h", i, obs_a(), exp_a());
      end
    end
    idle();
    for (int i = 0; i < 64; i++) begin
      get_a = 1;
      tick();
      total++;
      if (obs_a() !== exp_a() || dout_a !== 8'(i)) begin
        bad++;
        $display("FAIL drain[%0d]: got %h want %h", i, obs_a(), exp_a());
      end
    end
    idle();
    tick();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL drain_idle: got %h want %h", obs_a(), exp_a());
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 64; i++) begin
      put_a = 1; din_a = 8'(i + 100);
      tick();
    end
    put_a = 1; din_a = 8'hEE;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL put_full: got %h want %h", obs_a(), exp_a());
    end
    for (int i = 0; i < 64; i++) begin
      get_a = 1;
      tick();
      total++;
      if (obs_a() !== exp_a()) begin
        bad++;
        $display("FAIL intact[%0d]: got %h want %h", i, obs_a(), exp_a());
      end
    end
    get_a = 1;
    tick();
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL get_empty: got %h want %h", obs_a(), exp_a());
    end
    fl_a = 1; put_a = 1; din_a = 8'h33;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL flush: got %h want %h", obs_a(), exp_a());
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) begin
      put_a = 1; din_a = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      put_a = 1; get_a = 1; din_a = 8'($urandom);
      tick();
      total++;
      if (obs_a() !== exp_a()) begin
        bad++;
        $display("FAIL pg_mid[%0d]: got %h want %h", i, obs_a(), exp_a());
      end
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      get_a = 1;
      tick();
    end
    put_a = 1; get_a = 1; din_a = 8'h5C;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL pg_empty: got %h want %h", obs_a(), exp_a());
    end
    fl_a = 1;
    tick();
    idle();
    while (qa.size() < 64) begin
      put_a = 1; din_a = 8'($urandom);
      tick();
    end
    put_a = 1; get_a = 1; din_a = 8'hF0;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL pg_full: got %h want %h", obs_a(), exp_a());
    end
    get_a = 1;
    tick();
    idle();
    total++;
    if (obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL pg_full_next: got %h want %h", obs_a(), exp_a());
    end
    fl_a = 1;
    tick();
    idle();
  endtask

  task automatic test_fwft();
    put_b = 1; din_b = 8'hA5;
    tick();
    idle();
    total++;
    if (obs_b() !== exp_b() || dout_b !== 8'hA5) begin
      bad++;
      $display("FAIL fwft_a5: got %h want %h", obs_b(), exp_b());
    end
    put_b = 1; din_b = 8'h5A;
    tick();
    idle();
    get_b = 1;
    tick();
    idle();
    total++;
    if (obs_b() !== exp_b() || dout_b !== 8'h5A) begin
      bad++;
      $display("FAIL fwft_5a: got %h want %h", obs_b(), exp_b());
    end
    get_b = 1;
    tick();
    idle();
    total++;
    if (obs_b() !== exp_b() || dv_b !== 1'b0) begin
      bad++;
      $display("FAIL fwft_empty: got %h want %h", obs_b(), exp_b());
    end
  endtask

  task automatic test_thresholds();
    logic [4:0] ae_seen, af_seen;
    ae_seen = {4'b0, ae_b};
    af_seen = {4'b0, af_b};
    for (int i = 1; i <= 4; i++) begin
      put_b = 1; din_b = 8'($urandom);
      tick();
      ae_seen[i] = ae_b;
      af_seen[i] = af_b;
      total++;
      if (obs_b() !== exp_b()) begin
        bad++;
        $display("FAIL thr[%0d]: got %h want %h", i, obs_b(), exp_b());
      end
    end
    idle();
    total++;
    if (ae_seen !== 5'b00011 || af_seen !== 5'b11100) begin
      bad++;
      $display("FAIL thr_seq: got ae=%b af=%b want ae=00011 af=11100",
               ae_seen, af_seen);
    end
    fl_b = 1;
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      put_a = 1'($urandom); get_a = 1'($urandom);
      din_a = 8'($urandom); fl_a = ($urandom_range(0, 39) == 0);
      put_b = 1'($urandom); get_b = 1'($urandom);
      din_b = 8'($urandom); fl_b = ($urandom_range(0, 29) == 0);
      tick();
      total++;
      if (obs_a() !== exp_a()) begin
        bad++;
        $display("FAIL rand_a[%0d]: got %h want %h", i, obs_a(), exp_a());
      end
      total++;
      if (obs_b() !== exp_b()) begin
        bad++;
        $display("FAIL rand_b[%0d]: got %h want %h", i, obs_b(), exp_b());
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_boundary();
    test_simultaneous();
    test_fwft();
    test_thresholds();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
